// File: rtl/leaky_relu_deskew_collector.sv
// Deskews per-column leaky-ReLU samples through small FIFOs and emits full rows
// over a valid/ready handshake; columns cannot stall, so overflow drops and flags.
`timescale 1ns/1ps
module leaky_relu_deskew_collector #(
  parameter int N      = 2,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_in,
  input  logic [N-1:0]        lr_valid_in,
  input  logic [N*DATA_W-1:0] lr_data_in,
  output logic                row_valid_out,
  input  logic                row_ready_in,
  output logic [N*DATA_W-1:0] row_data_out,
  output logic [15:0]         row_count_out,
  output logic [N-1:0]        overflow_out,
  output logic                all_empty_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [N-1:0]        col_nonempty;
  logic [N-1:0]        col_push;
  logic [N-1:0]        col_drop;
  logic [N*DATA_W-1:0] col_head;

  logic                row_valid_q, row_valid_d;
  logic [N*DATA_W-1:0] row_data_q, row_data_d;
  logic [15:0]         row_count_q, row_count_d;
  logic [N-1:0]        overflow_q, overflow_d;

  logic load;
  logic transfer;

  assign transfer = row_valid_q & row_ready_in;
  // A load both refills the output slot and pops every column head in the same cycle.
  assign load     = (&col_nonempty) & (~row_valid_q | row_ready_in);

  for (genvar i = 0; i < N; i++) begin : g_col
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              full;

    assign full            = (cnt_q == FULL_CNT);
    assign col_nonempty[i] = (cnt_q != '0);
    // A full column still accepts a sample when the load frees its head slot this cycle.
    assign col_push[i]     = lr_valid_in[i] & (~full | load);
    assign col_drop[i]     = lr_valid_in[i] & full & ~load;
    assign col_head[i*DATA_W +: DATA_W] = mem_q[rd_ptr_q];

    always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (clear_in) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        cnt_d    = '0;
      end else begin
        if (col_push[i]) wr_ptr_d = wr_ptr_q + PW'(1);
        if (load)        rd_ptr_d = rd_ptr_q + PW'(1);
        case ({col_push[i], load})
          2'b10:   cnt_d = cnt_q + CW'(1);
          2'b01:   cnt_d = cnt_q - CW'(1);
          default: cnt_d = cnt_q;
        endcase
      end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    // NOTE: sample storage is not reset; zeroed pointers and counts make stale entries unreachable.
    always_ff @(posedge clk) begin
      if (col_push[i] && !clear_in) mem_q[wr_ptr_q] <= lr_data_in[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    row_valid_d = row_valid_q;
    row_data_d  = row_data_q;
    row_count_d = row_count_q;
    overflow_d  = overflow_q;
    if (clear_in) begin
      row_valid_d = 1'b0;
      row_data_d  = '0;
      row_count_d = '0;
      overflow_d  = '0;
    end else begin
      if (transfer) row_count_d = row_count_q + 16'd1;
      if (load) begin
        row_valid_d = 1'b1;
        row_data_d  = col_head;
      end else if (transfer) begin
        row_valid_d = 1'b0;
      end
      overflow_d = overflow_q | col_drop;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_valid_q <= 1'b0;
      row_data_q  <= '0;
      row_count_q <= '0;
      overflow_q  <= '0;
    end else begin
      row_valid_q <= row_valid_d;
      row_data_q  <= row_data_d;
      row_count_q <= row_count_d;
      overflow_q  <= overflow_d;
    end
  end

  assign row_valid_out = row_valid_q;
  assign row_data_out  = row_data_q;
  assign row_count_out = row_count_q;
  assign overflow_out  = overflow_q;
  assign all_empty_out = ~(|col_nonempty) & ~row_valid_q;

endmodule
